// File: rtl/fifo_index_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fifo_index_ctrl_pkg
//
// Purpose : Shared definitions for the FIFO index controller and its grant
//           sub-block: the width helper used to size pointers and the
//           occupancy counter, the simultaneous_push_pop encodings, and the
//           modulo-depth pointer advance.
//
// Contents:
//   SPP_POP_WINS / SPP_BOTH   encodings of simultaneous_push_pop
//   log_width(n)              bits needed to index n items (minimum 1)
//   max3(a, b, c)             largest of three integers
//   wrap_add(a, b, modulus)   (a + b) mod modulus, for a < modulus and
//                             b <= modulus
//
// Optional feature macro used by the top: FIFO_INDEX_CTRL_HWM_EN
// ---------------------------------------------------------------------------
package fifo_index_ctrl_pkg;

    // simultaneous_push_pop encodings
    localparam int SPP_POP_WINS = 0;   // a granted pop forces the push grant to 0
    localparam int SPP_BOTH     = 1;   // push and pop may both be granted

    // Number of bits needed to represent values 0 .. n-1, never below 1 so
    // that a depth-1 FIFO still gets a legal one-bit pointer.
    function automatic int log_width(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Pointer advance modulo depth.  The grant logic never accepts more than
    // depth entries in one cycle and pointers are always below depth, so the
    // sum is below 2*depth and a single conditional subtract replaces a
    // general modulo operator.
    function automatic int wrap_add(input int a, input int b, input int modulus);
        int s;
        s = a + b;
        if (modulus <= 0) begin
            return 0;
        end
        if (s >= modulus) begin
            s = s - modulus;
        end
        return s;
    endfunction

endpackage : fifo_index_ctrl_pkg

// File: rtl/fifo_index_grant.sv
// ---------------------------------------------------------------------------
// fifo_index_grant
//
// Purpose : Purely combinational arbitration of per-cycle push/pop entry
//           requests against the current FIFO occupancy.  Produces the
//           accepted counts and the stall indications.
//
// Parameters:
//   depth                  FIFO entries
//   push_width/pop_width   width of the request / accept counts
//   simultaneous_push_pop  SPP_BOTH or SPP_POP_WINS (see package)
//   cnt_width              occupancy width
//
// Ports:
//   i_grant_en    1 = normal operation, 0 = all grants and stalls forced low
//   i_push_req    entries requested to push this cycle
//   i_pop_req     entries requested to pop this cycle
//   i_count       current occupancy
//   o_push_acc    entries accepted for push
//   o_pop_acc     entries accepted for pop
//   o_push_stall  fewer pushes accepted than requested
//   o_pop_stall   fewer pops accepted than requested
// ---------------------------------------------------------------------------
module fifo_index_grant
    import fifo_index_ctrl_pkg::*;
#(
    parameter int depth                 = 8,
    parameter int push_width            = 2,
    parameter int pop_width             = 2,
    parameter int simultaneous_push_pop = SPP_BOTH,
    parameter int cnt_width             = log_width(depth + 1)
) (
    input  logic                  i_grant_en,
    input  logic [push_width-1:0] i_push_req,
    input  logic [pop_width-1:0]  i_pop_req,
    input  logic [cnt_width-1:0]  i_count,
    output logic [push_width-1:0] o_push_acc,
    output logic [pop_width-1:0]  o_pop_acc,
    output logic                  o_push_stall,
    output logic                  o_pop_stall
);

    // One guard bit above the widest operand so that depth - count + pop
    // cannot wrap before the min() is taken.
    localparam int AW = max3(cnt_width, push_width, pop_width) + 1;

    logic [AW-1:0] w_push_req;
    logic [AW-1:0] w_pop_req;
    logic [AW-1:0] w_count;
    logic [AW-1:0] w_depth;
    logic [AW-1:0] w_room;
    logic [AW-1:0] w_pop_x;
    logic [AW-1:0] w_push_x;

    assign w_push_req = AW'(i_push_req);
    assign w_pop_req  = AW'(i_pop_req);
    assign w_count    = AW'(i_count);
    assign w_depth    = AW'(depth);

    always_comb begin
        // Pops are limited by what is stored now; a same-cycle push never
        // satisfies a same-cycle pop.
        w_pop_x = (w_pop_req < w_count) ? w_pop_req : w_count;

        // Free space; when both directions may be granted, the slots being
        // vacated this cycle are reusable by this cycle's push.
        w_room = w_depth - w_count;
        if (simultaneous_push_pop == SPP_BOTH) begin
            w_room = w_room + w_pop_x;
        end

        w_push_x = (w_push_req < w_room) ? w_push_req : w_room;
        if ((simultaneous_push_pop == SPP_POP_WINS) && (w_pop_x != '0)) begin
            w_push_x = '0;
        end

        // Grants are masked while the controller is held in reset so that
        // no entries move downstream.
        if (!i_grant_en) begin
            w_pop_x  = '0;
            w_push_x = '0;
        end
    end

    // The min() results never exceed the request, so truncating to the
    // port width afterwards is lossless.
    assign o_push_acc   = push_width'(w_push_x);
    assign o_pop_acc    = pop_width'(w_pop_x);
    assign o_push_stall = i_grant_en && (w_push_x < w_push_req);
    assign o_pop_stall  = i_grant_en && (w_pop_x < w_pop_req);

endmodule : fifo_index_grant

// File: rtl/fifo_index_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_index_ctrl
//
// Purpose : Multi-entry FIFO index controller.  Accepts per-cycle push/pop
//           entry requests, grants as many as occupancy allows (never
//           overflowing or underflowing), and tracks the write pointer, read
//           pointer, occupancy and status flags.  push_acc/pop_acc are meant
//           to drive the FIFO storage and a downstream index checker.
//
// Parameters:
//   depth                  FIFO entries (> 0)
//   push_width/pop_width   width of request/accept counts
//   simultaneous_push_pop  1 = push and pop may both be granted in a cycle,
//                          0 = a granted pop forces the push grant to 0
//   ptr_width              pointer width, log(depth), minimum 1
//   cnt_width              occupancy width, log(depth+1)
//
// Ports:
//   clk         clock, rising edge
//   reset_n     synchronous reset, active low
//   push_req    entries requested to push this cycle
//   pop_req     entries requested to pop this cycle
//   push_acc    entries accepted for push (combinational)
//   pop_acc     entries accepted for pop (combinational)
//   wr_ptr      next write index
//   rd_ptr      next read index
//   count       current occupancy
//   full        count == depth
//   empty       count == 0
//   push_stall  push_acc < push_req (combinational)
//   pop_stall   pop_acc < pop_req (combinational)
//   ovf_seen    sticky: a push was stalled at some point since reset
//   hwm         high-water mark of count; present only when
//               FIFO_INDEX_CTRL_HWM_EN is defined
// ---------------------------------------------------------------------------
module fifo_index_ctrl
    import fifo_index_ctrl_pkg::*;
#(
    parameter int depth                 = 8,
    parameter int push_width            = 2,
    parameter int pop_width             = 2,
    parameter int simultaneous_push_pop = SPP_BOTH,
    parameter int ptr_width             = log_width(depth),
    parameter int cnt_width             = log_width(depth + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [push_width-1:0] push_req,
    input  logic [pop_width-1:0]  pop_req,
    output logic [push_width-1:0] push_acc,
    output logic [pop_width-1:0]  pop_acc,
    output logic [ptr_width-1:0]  wr_ptr,
    output logic [ptr_width-1:0]  rd_ptr,
    output logic [cnt_width-1:0]  count,
    output logic                  full,
    output logic                  empty,
    output logic                  push_stall,
    output logic                  pop_stall,
    output logic                  ovf_seen
`ifdef FIFO_INDEX_CTRL_HWM_EN
    ,
    output logic [cnt_width-1:0]  hwm
`endif
);

    // A zero-entry FIFO has no meaningful pointers; refuse to elaborate.
    generate
        if (depth <= 0) begin : g_depth_check
            $error("fifo_index_ctrl: depth must be greater than 0");
        end
    endgenerate

    localparam int AW = max3(cnt_width, push_width, pop_width) + 1;

    logic [ptr_width-1:0] r_wr_ptr;
    logic [ptr_width-1:0] r_rd_ptr;
    logic [cnt_width-1:0] r_count;
    logic                 r_ovf_seen;

    logic [push_width-1:0] w_push_acc;
    logic [pop_width-1:0]  w_pop_acc;
    logic                  w_push_stall;
    logic                  w_pop_stall;
    logic [AW-1:0]         w_count_next_x;
    logic [cnt_width-1:0]  w_count_next;
    logic [ptr_width-1:0]  w_wr_ptr_next;
    logic [ptr_width-1:0]  w_rd_ptr_next;

    // -----------------------------------------------------------------------
    // Grant arbitration (zero latency from request)
    // -----------------------------------------------------------------------
    fifo_index_grant #(
        .depth                 (depth),
        .push_width            (push_width),
        .pop_width             (pop_width),
        .simultaneous_push_pop (simultaneous_push_pop),
        .cnt_width             (cnt_width)
    ) u_grant (
        .i_grant_en   (reset_n),
        .i_push_req   (push_req),
        .i_pop_req    (pop_req),
        .i_count      (r_count),
        .o_push_acc   (w_push_acc),
        .o_pop_acc    (w_pop_acc),
        .o_push_stall (w_push_stall),
        .o_pop_stall  (w_pop_stall)
    );

    // -----------------------------------------------------------------------
    // Next-state arithmetic
    // -----------------------------------------------------------------------
    // The grant block guarantees count + push - pop stays in 0..depth, so
    // the wide result always fits in cnt_width bits.
    assign w_count_next_x = AW'(r_count) + AW'(w_push_acc) - AW'(w_pop_acc);
    assign w_count_next   = cnt_width'(w_count_next_x);

    // Pointers wrap at depth rather than 2^ptr_width so that non-power-of-2
    // depths index only valid storage locations.
    assign w_wr_ptr_next = ptr_width'(wrap_add(int'(r_wr_ptr), int'(w_push_acc), depth));
    assign w_rd_ptr_next = ptr_width'(wrap_add(int'(r_rd_ptr), int'(w_pop_acc), depth));

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_ovf_seen <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
            r_count  <= w_count_next;
            if (w_push_stall) begin
                r_ovf_seen <= 1'b1;
            end
        end
    end

`ifdef FIFO_INDEX_CTRL_HWM_EN
    // -----------------------------------------------------------------------
    // High-water mark: tracks the largest occupancy reached, including the
    // value being loaded this cycle.
    // -----------------------------------------------------------------------
    logic [cnt_width-1:0] r_hwm;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hwm <= '0;
        end else if (w_count_next > r_hwm) begin
            r_hwm <= w_count_next;
        end
    end

    assign hwm = r_hwm;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign push_acc   = w_push_acc;
    assign pop_acc    = w_pop_acc;
    assign push_stall = w_push_stall;
    assign pop_stall  = w_pop_stall;
    assign wr_ptr     = r_wr_ptr;
    assign rd_ptr     = r_rd_ptr;
    assign count      = r_count;
    assign full       = (r_count == cnt_width'(depth));
    assign empty      = (r_count == '0);
    assign ovf_seen   = r_ovf_seen;

endmodule : fifo_index_ctrl

// File: tb/tb_fifo_index_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo_index_ctrl
//
// Three controllers share one request stream:
//   dut 0 : depth 8, simultaneous_push_pop = 1
//   dut 1 : depth 6, simultaneous_push_pop = 1  (non-power-of-2 wrap)
//   dut 2 : depth 8, simultaneous_push_pop = 0  (pop wins)
// The reference model tracks total entries pushed and popped since reset;
// occupancy and pointers are derived from those totals.  The driver pushes
// the expected response per DUT per cycle into a queue; a monitor pops and
// compares grants before the edge and state after it.
// Optional feature macro: FIFO_INDEX_CTRL_HWM_EN
// ---------------------------------------------------------------------------
module tb_fifo_index_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n = 1'b0;
    logic [1:0] push_req = '0;
    logic [1:0] pop_req  = '0;

    logic [1:0] a_pacc, a_placc, b_pacc, b_placc, c_pacc, c_placc;
    logic [2:0] a_wr, a_rd, b_wr, b_rd, c_wr, c_rd;
    logic [3:0] a_cnt, c_cnt;
    logic [2:0] b_cnt;
    logic a_full, a_empty, a_pst, a_plst, a_ovf;
    logic b_full, b_empty, b_pst, b_plst, b_ovf;
    logic c_full, c_empty, c_pst, c_plst, c_ovf;
`ifdef FIFO_INDEX_CTRL_HWM_EN
    logic [3:0] a_hwm, c_hwm;
    logic [2:0] b_hwm;
`endif

    fifo_index_ctrl #(.depth(8), .simultaneous_push_pop(1)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .push_req(push_req), .pop_req(pop_req),
        .push_acc(a_pacc), .pop_acc(a_placc), .wr_ptr(a_wr), .rd_ptr(a_rd),
        .count(a_cnt), .full(a_full), .empty(a_empty), .push_stall(a_pst),
        .pop_stall(a_plst), .ovf_seen(a_ovf)
`ifdef FIFO_INDEX_CTRL_HWM_EN
        , .hwm(a_hwm)
`endif
    );

    fifo_index_ctrl #(.depth(6), .simultaneous_push_pop(1)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .push_req(push_req), .pop_req(pop_req),
        .push_acc(b_pacc), .pop_acc(b_placc), .wr_ptr(b_wr), .rd_ptr(b_rd),
        .count(b_cnt), .full(b_full), .empty(b_empty), .push_stall(b_pst),
        .pop_stall(b_plst), .ovf_seen(b_ovf)
`ifdef FIFO_INDEX_CTRL_HWM_EN
        , .hwm(b_hwm)
`endif
    );

    fifo_index_ctrl #(.depth(8), .simultaneous_push_pop(0)) u_dut_c (
        .clk(clk), .reset_n(reset_n), .push_req(push_req), .pop_req(pop_req),
        .push_acc(c_pacc), .pop_acc(c_placc), .wr_ptr(c_wr), .rd_ptr(c_rd),
        .count(c_cnt), .full(c_full), .empty(c_empty), .push_stall(c_pst),
        .pop_stall(c_plst), .ovf_seen(c_ovf)
`ifdef FIFO_INDEX_CTRL_HWM_EN
        , .hwm(c_hwm)
`endif
    );

    typedef struct {
        int dut;
        int pacc, placc, pst, plst;
        int cnt, wr, rd, ovf, hwm;
    } exp_t;

    exp_t q[$];

    int vectors    = 0;
    int miscompares = 0;
    int n_checks   = 0;
    int n_pushed   = 0;
    int n_checked  = 0;
    int cyc        = 0;

    // reference model state: totals since the last reset
    int m_pushed[3];
    int m_popped[3];
    int m_ovf[3];
    int m_hwm[3];

    function automatic int dep_of(input int d);
        return (d == 1) ? 6 : 8;
    endfunction

    function automatic int spp_of(input int d);
        return (d == 2) ? 0 : 1;
    endfunction

    function automatic void chk(input string nm, input int d, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc %0d: got %0d, expected %0d", nm, d, cyc, act, exp_v);
        end
    endfunction

    task automatic get_grants(input int d, output int pa, output int pl, output int ps, output int pls);
        case (d)
            0: begin pa = int'(a_pacc); pl = int'(a_placc); ps = int'(a_pst); pls = int'(a_plst); end
            1: begin pa = int'(b_pacc); pl = int'(b_placc); ps = int'(b_pst); pls = int'(b_plst); end
            default: begin pa = int'(c_pacc); pl = int'(c_placc); ps = int'(c_pst); pls = int'(c_plst); end
        endcase
    endtask

    task automatic get_state(input int d, output int cnt, output int wr, output int rd,
                             output int fl, output int em, output int ov, output int hw);
        hw = 0;
        case (d)
            0: begin cnt = int'(a_cnt); wr = int'(a_wr); rd = int'(a_rd);
                     fl = int'(a_full); em = int'(a_empty); ov = int'(a_ovf);
`ifdef FIFO_INDEX_CTRL_HWM_EN
                     hw = int'(a_hwm);
`endif
               end
            1: begin cnt = int'(b_cnt); wr = int'(b_wr); rd = int'(b_rd);
                     fl = int'(b_full); em = int'(b_empty); ov = int'(b_ovf);
`ifdef FIFO_INDEX_CTRL_HWM_EN
                     hw = int'(b_hwm);
`endif
               end
            default: begin cnt = int'(c_cnt); wr = int'(c_wr); rd = int'(c_rd);
                     fl = int'(c_full); em = int'(c_empty); ov = int'(c_ovf);
`ifdef FIFO_INDEX_CTRL_HWM_EN
                     hw = int'(c_hwm);
`endif
               end
        endcase
    endtask

    // Drive one cycle of stimulus and queue the expected response per DUT.
    task automatic step(input bit rn, input int pu, input int po);
        @(negedge clk);
        reset_n  = rn;
        push_req = 2'(pu);
        pop_req  = 2'(po);
        cyc++;
        $display("cyc %0d reset_n=%0b push_req=%0d pop_req=%0d", cyc, rn, pu, po);
        for (int d = 0; d < 3; d++) begin
            exp_t e;
            int occ, room, pa, pl;
            e.dut = d;
            if (!rn) begin
                pa = 0; pl = 0;
                e.pst = 0; e.plst = 0;
                m_pushed[d] = 0; m_popped[d] = 0; m_ovf[d] = 0; m_hwm[d] = 0;
            end else begin
                occ  = m_pushed[d] - m_popped[d];
                pl   = (po < occ) ? po : occ;
                room = dep_of(d) - occ + (spp_of(d) != 0 ? pl : 0);
                pa   = (pu < room) ? pu : room;
                if (spp_of(d) == 0 && pl > 0) pa = 0;
                e.pst  = (pa < pu) ? 1 : 0;
                e.plst = (pl < po) ? 1 : 0;
                m_pushed[d] += pa;
                m_popped[d] += pl;
                if (e.pst != 0) m_ovf[d] = 1;
                occ = m_pushed[d] - m_popped[d];
                if (occ > m_hwm[d]) m_hwm[d] = occ;
            end
            e.pacc  = pa;
            e.placc = pl;
            e.cnt   = m_pushed[d] - m_popped[d];
            e.wr    = m_pushed[d] % dep_of(d);
            e.rd    = m_popped[d] % dep_of(d);
            e.ovf   = m_ovf[d];
            e.hwm   = m_hwm[d];
            q.push_back(e);
            n_pushed++;
        end
        vectors++;
    endtask

    // Monitor: grants are sampled mid-cycle, state just after the edge.
    initial begin
        exp_t cur[3];
        bit   have;
        int pa, pl, ps, pls, cnt, wr, rd, fl, em, ov, hw;
        forever begin
            @(negedge clk);
            #2;
            have = (q.size() >= 3);
            if (have) begin
                for (int k = 0; k < 3; k++) begin
                    cur[k] = q.pop_front();
                    get_grants(cur[k].dut, pa, pl, ps, pls);
                    chk("push_acc",   cur[k].dut, pa,  cur[k].pacc);
                    chk("pop_acc",    cur[k].dut, pl,  cur[k].placc);
                    chk("push_stall", cur[k].dut, ps,  cur[k].pst);
                    chk("pop_stall",  cur[k].dut, pls, cur[k].plst);
                end
            end
            @(posedge clk);
            #1;
            if (have) begin
                for (int k = 0; k < 3; k++) begin
                    get_state(cur[k].dut, cnt, wr, rd, fl, em, ov, hw);
                    chk("count",    cur[k].dut, cnt, cur[k].cnt);
                    chk("wr_ptr",   cur[k].dut, wr,  cur[k].wr);
                    chk("rd_ptr",   cur[k].dut, rd,  cur[k].rd);
                    chk("full",     cur[k].dut, fl,  (cur[k].cnt == dep_of(cur[k].dut)) ? 1 : 0);
                    chk("empty",    cur[k].dut, em,  (cur[k].cnt == 0) ? 1 : 0);
                    chk("ovf_seen", cur[k].dut, ov,  cur[k].ovf);
`ifdef FIFO_INDEX_CTRL_HWM_EN
                    chk("hwm",      cur[k].dut, hw,  cur[k].hwm);
`endif
                    n_checked++;
                end
            end
        end
    end

    initial begin
        int bias;
        // reset held with a push request pending
        step(0, 3, 0);
        step(0, 3, 0);
        // fill: 3,3,2 accepted, overflow becomes sticky
        step(1, 3, 0);
        step(1, 3, 0);
        step(1, 3, 0);
        // simultaneous push/pop at full
        step(1, 2, 2);
        // wrap on depth 6: push 3, push 3, pop 3, push 3
        step(0, 0, 0);
        step(1, 3, 0);
        step(1, 3, 0);
        step(1, 0, 3);
        step(1, 3, 0);
        // pop from empty with a same-cycle push
        step(0, 0, 0);
        step(1, 1, 1);
        // high-water mark run with a mid-run reset
        step(0, 0, 0);
        step(1, 3, 0);
        step(1, 2, 0);
        step(1, 0, 3);
        step(1, 0, 1);
        step(0, 3, 3);
        step(1, 0, 0);
        // randomized phases alternating between push-heavy and pop-heavy
        for (int i = 0; i < 400; i++) begin
            bias = (i / 50) % 2;
            step($urandom_range(0, 59) != 0,
                 (bias == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 2)),
                 (bias == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 3)));
        end
        step(1, 0, 0);
        @(posedge clk);
        #3;
        n_checks++;
        if (q.size() != 0 || n_checked != n_pushed) begin
            miscompares++;
            $display("FAIL drain: checked %0d of %0d expected responses", n_checked, n_pushed);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_fifo_index_ctrl
